// File: rtl/sad_pkg.sv
// Shared types and constants for the SAD block accumulator and its neighbours.
package sad_pkg;

    localparam int unsigned SAD_W_DEF    = 32;
    localparam int unsigned COORD_W_DEF  = 8;
    // Seed value the downstream comparator starts its minimum search from
    localparam int unsigned SAD_MAX_INIT = 32767;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } sad_state_t;

    function automatic int unsigned sad_beats(input int unsigned blk_w,
                                              input int unsigned blk_h,
                                              input int unsigned lanes);
        return (blk_w * blk_h) / lanes;
    endfunction

endpackage

// File: rtl/sad_block_accumulator_if.sv
// Pixel-in / result-out handshake bundle for sad_block_accumulator.
// Optional SAD_EARLY_TERM_EN adds threshold_sad and early_term_out.
interface sad_block_accumulator_if #(
    parameter int unsigned PIX_W   = 8,
    parameter int unsigned LANES   = 4,
    parameter int unsigned SAD_W   = sad_pkg::SAD_W_DEF,
    parameter int unsigned COORD_W = sad_pkg::COORD_W_DEF
);

    logic                     start;
    logic [COORD_W-1:0]       cand_row;
    logic [COORD_W-1:0]       cand_column;
    logic                     pix_valid;
    logic                     pix_ready;
    logic [LANES*PIX_W-1:0]   cur_pix;
    logic [LANES*PIX_W-1:0]   ref_pix;
    logic                     sad_valid;
    logic                     sad_ready;
    logic [SAD_W-1:0]         sad_out;
    logic [COORD_W-1:0]       sad_row_out;
    logic [COORD_W-1:0]       sad_column_out;
    logic                     busy;
`ifdef SAD_EARLY_TERM_EN
    logic [SAD_W-1:0]         threshold_sad;
    logic                     early_term_out;
`endif

    modport master (
        output start, cand_row, cand_column, pix_valid, cur_pix, ref_pix, sad_ready,
`ifdef SAD_EARLY_TERM_EN
        output threshold_sad,
        input  early_term_out,
`endif
        input  pix_ready, sad_valid, sad_out, sad_row_out, sad_column_out, busy
    );

    modport slave (
        input  start, cand_row, cand_column, pix_valid, cur_pix, ref_pix, sad_ready,
`ifdef SAD_EARLY_TERM_EN
        input  threshold_sad,
        output early_term_out,
`endif
        output pix_ready, sad_valid, sad_out, sad_row_out, sad_column_out, busy
    );

endinterface

// File: rtl/sad_abs_diff_tree.sv
// Combinational per-lane |cur - ref| summed across all lanes of one beat.
module sad_abs_diff_tree #(
    parameter  int unsigned LANES = 4,
    parameter  int unsigned PIX_W = 8,
    localparam int unsigned SUM_W = PIX_W + $clog2(LANES)
) (
    input  logic [LANES*PIX_W-1:0] i_cur,
    input  logic [LANES*PIX_W-1:0] i_ref,
    output logic [SUM_W-1:0]       o_sum_c
);

    logic [PIX_W-1:0] w_diff [LANES];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [PIX_W-1:0] w_c;
        logic [PIX_W-1:0] w_r;
        assign w_c       = i_cur[g*PIX_W +: PIX_W];
        assign w_r       = i_ref[g*PIX_W +: PIX_W];
        assign w_diff[g] = (w_c >= w_r) ? (w_c - w_r) : (w_r - w_c);
    end

    always_comb begin
        o_sum_c = '0;
        for (int i = 0; i < LANES; i++) begin
            o_sum_c = o_sum_c + SUM_W'(w_diff[i]);
        end
    end

endmodule

// File: rtl/sad_block_accumulator.sv
// Accumulates the SAD of one candidate block and hands it to the comparator.
// Optional early termination is enabled with `define SAD_EARLY_TERM_EN.
module sad_block_accumulator
    import sad_pkg::*;
#(
    parameter int unsigned PIX_W   = 8,
    parameter int unsigned LANES   = 4,
    parameter int unsigned BLOCK_W = 8,
    parameter int unsigned BLOCK_H = 8,
    parameter int unsigned SAD_W   = SAD_W_DEF,
    parameter int unsigned COORD_W = COORD_W_DEF
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    sad_block_accumulator_if.slave  io_bus
);

    localparam int unsigned BEATS  = sad_beats(BLOCK_W, BLOCK_H, LANES);
    localparam int unsigned TREE_W = PIX_W + $clog2(LANES);
    localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    if ((BEATS * LANES != BLOCK_W * BLOCK_H) || (BEATS < 1)) begin : g_chk_beats
        $error("BLOCK_W*BLOCK_H must be a non-zero multiple of LANES");
    end
    if (SAD_W < PIX_W + $clog2(BLOCK_W * BLOCK_H)) begin : g_chk_sad_w
        $error("SAD_W too narrow for a full block SAD");
    end

    sad_state_t         r_state;
    sad_state_t         w_state_nxt;
    logic               w_start;
    logic               w_load;
    logic               w_release;
    logic               w_beat_acc;
    logic               w_last_beat;
    logic               w_frozen;
    logic [TREE_W-1:0]  w_tree_sum;
    logic [SAD_W-1:0]   w_acc_nxt;

    logic               r_pix_ready;
    logic               r_busy;
    logic               r_s1_valid;
    logic [TREE_W-1:0]  r_s1_sum;
    logic [SAD_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_beat;
    logic [COORD_W-1:0] r_row_tag;
    logic [COORD_W-1:0] r_col_tag;
    logic               r_sad_valid;
    logic [SAD_W-1:0]   r_sad_out;
    logic [COORD_W-1:0] r_row_out;
    logic [COORD_W-1:0] r_col_out;

    sad_abs_diff_tree #(
        .LANES (LANES),
        .PIX_W (PIX_W)
    ) u_tree (
        .i_cur   (io_bus.cur_pix),
        .i_ref   (io_bus.ref_pix),
        .o_sum_c (w_tree_sum)
    );

    assign w_beat_acc  = r_pix_ready & io_bus.pix_valid;
    assign w_last_beat = w_beat_acc & (r_beat == CNT_W'(BEATS - 1));
    assign w_acc_nxt   = (r_s1_valid && !w_frozen) ? (r_acc + SAD_W'(r_s1_sum)) : r_acc;

    always_ff @(posedge i_clk or posedge i_rst) begin : p_state
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin : p_fsm
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_load      = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (io_bus.start) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (w_last_beat) w_state_nxt = ST_DRAIN;
            end
            // Stage 2 absorbs the last beat this cycle; capture its sum directly
            ST_DRAIN: begin
                w_load      = 1'b1;
                w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (io_bus.sad_ready) begin
                    w_release   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin : p_datapath
        if (i_rst) begin
            r_pix_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_s1_valid  <= 1'b0;
            r_s1_sum    <= '0;
            r_acc       <= '0;
            r_beat      <= '0;
            r_row_tag   <= '0;
            r_col_tag   <= '0;
            r_sad_valid <= 1'b0;
            r_sad_out   <= '0;
            r_row_out   <= '0;
            r_col_out   <= '0;
        end else begin
            r_pix_ready <= (w_state_nxt == ST_ACCUM);
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_s1_valid  <= w_beat_acc;
            if (w_beat_acc) r_s1_sum <= w_tree_sum;

            if (w_start) begin
                r_row_tag <= io_bus.cand_row;
                r_col_tag <= io_bus.cand_column;
                r_acc     <= '0;
                r_beat    <= '0;
            end else begin
                r_acc <= w_acc_nxt;
                if (w_beat_acc) r_beat <= r_beat + CNT_W'(1);
            end

            if (w_load) begin
                r_sad_valid <= 1'b1;
                r_sad_out   <= w_acc_nxt;
                r_row_out   <= r_row_tag;
                r_col_out   <= r_col_tag;
            end else if (w_release) begin
                r_sad_valid <= 1'b0;
            end
        end
    end

`ifdef SAD_EARLY_TERM_EN
    logic [SAD_W-1:0] r_thr;
    logic             r_early;

    // Strictly greater: a SAD equal to the threshold can still win the compare
    assign w_frozen = (r_acc > r_thr);

    always_ff @(posedge i_clk or posedge i_rst) begin : p_early
        if (i_rst) begin
            r_thr   <= '0;
            r_early <= 1'b0;
        end else begin
            if (w_start) r_thr <= io_bus.threshold_sad;
            if (w_load)         r_early <= (w_acc_nxt > r_thr);
            else if (w_release) r_early <= 1'b0;
        end
    end

    assign io_bus.early_term_out = r_early;
`else
    assign w_frozen = 1'b0;
`endif

    assign io_bus.pix_ready      = r_pix_ready;
    assign io_bus.busy           = r_busy;
    assign io_bus.sad_valid      = r_sad_valid;
    assign io_bus.sad_out        = r_sad_out;
    assign io_bus.sad_row_out    = r_row_out;
    assign io_bus.sad_column_out = r_col_out;

endmodule

// File: tb/tb_sad_block_accumulator.sv
// Directed scoreboard bench for sad_block_accumulator (default 8x8 block, 4 lanes).
module tb_sad_block_accumulator;

    typedef struct {
        logic [31:0] sad;
        logic [7:0]  row;
        logic [7:0]  col;
        logic        early;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   n_push;
    int   n_pop;
    exp_t sb_q[$];

    logic        prev_hold;
    logic [31:0] prev_sad;
    logic [7:0]  prev_row;
    logic [7:0]  prev_col;

    sad_block_accumulator_if #(.PIX_W(8), .LANES(4), .SAD_W(32), .COORD_W(8)) bus ();

    sad_block_accumulator #(
        .PIX_W(8), .LANES(4), .BLOCK_W(8), .BLOCK_H(8), .SAD_W(32), .COORD_W(8)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", name, act, exp);
        end
    endtask

    // Monitor: compares popped expectations on each result handshake and checks hold stability
    always @(negedge clk) begin
        if (rst) begin
            prev_hold <= 1'b0;
        end else begin
            if (prev_hold && bus.sad_valid) begin
                chk("hold_sad_stable", bus.sad_out, prev_sad);
                chk("hold_row_stable", 32'(bus.sad_row_out), 32'(prev_row));
                chk("hold_col_stable", 32'(bus.sad_column_out), 32'(prev_col));
            end
            if (bus.sad_valid && bus.sad_ready) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got sad=%0d with no pending expectation", bus.sad_out);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    n_pop++;
                    chk("sad_out", bus.sad_out, e.sad);
                    chk("sad_row_out", 32'(bus.sad_row_out), 32'(e.row));
                    chk("sad_column_out", 32'(bus.sad_column_out), 32'(e.col));
`ifdef SAD_EARLY_TERM_EN
                    chk("early_term_out", 32'(bus.early_term_out), 32'(e.early));
`endif
                end
            end
            prev_hold <= bus.sad_valid && !bus.sad_ready;
            prev_sad  <= bus.sad_out;
            prev_row  <= bus.sad_row_out;
            prev_col  <= bus.sad_column_out;
        end
    end

    function automatic void gen_pix(input int mode, input int b,
                                    output logic [31:0] c, output logic [31:0] r);
        logic [7:0] cl;
        logic [7:0] rl;
        c = '0;
        r = '0;
        for (int l = 0; l < 4; l++) begin
            case (mode)
                0:       begin cl = 8'h80;          rl = 8'h80;  end
                1:       begin cl = 8'hFF;          rl = 8'h00;  end
                2:       begin cl = 8'h00;          rl = 8'hFF;  end
                3:       begin cl = 8'(b * 10 + l); rl = 8'd100; end
                4:       begin cl = 8'h10;          rl = 8'h30;  end
                5:       begin cl = 8'h05;          rl = 8'h02;  end
                6:       begin cl = 8'h20;          rl = 8'h11;  end
                default: begin cl = 8'h00;          rl = 8'h00;  end
            endcase
            c[l*8 +: 8] = cl;
            r[l*8 +: 8] = rl;
        end
    endfunction

    task automatic pulse_start(input logic [7:0] row, input logic [7:0] col, input logic [31:0] thr);
        bus.cand_row    = row;
        bus.cand_column = col;
`ifdef SAD_EARLY_TERM_EN
        bus.threshold_sad = thr;
`endif
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Present one beat and hold it until the DUT accepts it (bounded)
    task automatic send_beat(input logic [31:0] c, input logic [31:0] r);
        logic ok;
        ok = 1'b0;
        bus.pix_valid = 1'b1;
        bus.cur_pix   = c;
        bus.ref_pix   = r;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.pix_ready;
            @(posedge clk); #1;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL beat_accept_timeout: got pix_ready=0 want=1");
        end
    endtask

    task automatic run_cand(input logic [7:0] row, input logic [7:0] col, input logic [31:0] thr,
                            input int mode, input bit gap, input int hold, input bit stray,
                            input bit bump, input logic [31:0] exp_sad, input logic exp_early);
        exp_t        e;
        logic [31:0] c;
        logic [31:0] r;
        int          cnt;
        e.sad   = exp_sad;
        e.row   = row;
        e.col   = col;
        e.early = exp_early;
        sb_q.push_back(e);
        n_push++;
        bus.sad_ready = (hold == 0);
        pulse_start(row, col, thr);
        for (int b = 0; b < 16; b++) begin
            if (gap && (b % 2 == 1)) begin
                bus.pix_valid = 1'b0;
                @(posedge clk); #1;
            end
            if (bump && b == 5) begin
                bus.pix_valid = 1'b0;
                @(negedge clk);
                chk("busy_in_accum", 32'(bus.busy), 32'd1);
                @(posedge clk); #1;
                bus.cand_row    = 8'hAA;
                bus.cand_column = 8'hBB;
                bus.start       = 1'b1;
                @(posedge clk); #1;
                bus.start = 1'b0;
            end
            gen_pix(mode, b, c, r);
            send_beat(c, r);
        end
        bus.pix_valid = 1'b0;
        @(negedge clk);
        chk("valid_n_plus_1", 32'(bus.sad_valid), 32'd0);
        chk("drain_pix_ready", 32'(bus.pix_ready), 32'd0);
        @(negedge clk);
        chk("valid_n_plus_2", 32'(bus.sad_valid), 32'd1);
        cnt = 0;
        while (!(bus.sad_valid && bus.sad_ready) && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
            if (cnt == hold) begin
                bus.sad_ready   = 1'b1;
                bus.start       = stray;
                bus.cand_row    = 8'hEE;
                bus.cand_column = 8'hEE;
            end
            @(negedge clk);
        end
        if (!(bus.sad_valid && bus.sad_ready)) begin
            total++;
            bad++;
            $display("FAIL result_handshake_timeout: got sad_valid=%0d want=1", bus.sad_valid);
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("idle_busy_after", 32'(bus.busy), 32'd0);
        chk("valid_cleared", 32'(bus.sad_valid), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] c;
        logic [31:0] r;
        total  = 0;
        bad    = 0;
        n_push = 0;
        n_pop  = 0;
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.cand_row    = '0;
        bus.cand_column = '0;
        bus.pix_valid   = 1'b0;
        bus.cur_pix     = '0;
        bus.ref_pix     = '0;
        bus.sad_ready   = 1'b0;
`ifdef SAD_EARLY_TERM_EN
        bus.threshold_sad = '0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_sad_valid", 32'(bus.sad_valid), 32'd0);
        chk("rst_pix_ready", 32'(bus.pix_ready), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_sad_out", bus.sad_out, 32'd0);
        @(posedge clk); #1;

        // identical pixels
        run_cand(8'd3, 8'd5, 32'hFFFF_FFFF, 0, 1'b0, 0, 1'b0, 1'b0, 32'd0, 1'b0);
        // max difference, both polarities
        run_cand(8'd1, 8'd2, 32'hFFFF_FFFF, 1, 1'b0, 0, 1'b0, 1'b0, 32'd16320, 1'b0);
        run_cand(8'd2, 8'd1, 32'hFFFF_FFFF, 2, 1'b0, 0, 1'b0, 1'b0, 32'd16320, 1'b0);
        // ramp pattern, gaps in pix_valid, 10-cycle hold, stray Start with SADReady
        run_cand(8'h21, 8'h42, 32'hFFFF_FFFF, 3, 1'b1, 10, 1'b1, 1'b0, 32'd2776, 1'b0);
        // Start during ACCUM is ignored
        run_cand(8'd7, 8'd9, 32'hFFFF_FFFF, 4, 1'b0, 0, 1'b0, 1'b1, 32'd2048, 1'b0);

        // reset after 7 beats discards the candidate
        bus.sad_ready = 1'b1;
        pulse_start(8'd4, 8'd4, 32'hFFFF_FFFF);
        for (int b = 0; b < 7; b++) begin
            gen_pix(1, b, c, r);
            send_beat(c, r);
        end
        rst = 1'b1;
        #1;
        chk("midrst_sad_out", bus.sad_out, 32'd0);
        chk("midrst_row", 32'(bus.sad_row_out), 32'd0);
        chk("midrst_col", 32'(bus.sad_column_out), 32'd0);
        chk("midrst_valid", 32'(bus.sad_valid), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_pix_ready", 32'(bus.pix_ready), 32'd0);
        bus.pix_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_cand(8'd12, 8'd13, 32'hFFFF_FFFF, 5, 1'b0, 0, 1'b0, 1'b0, 32'd192, 1'b0);

`ifdef SAD_EARLY_TERM_EN
        run_cand(8'd6, 8'd6, 32'd100, 6, 1'b0, 0, 1'b0, 1'b0, 32'd120, 1'b1);
        run_cand(8'd8, 8'd8, 32'd960, 6, 1'b1, 3, 1'b0, 1'b0, 32'd960, 1'b0);
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        chk("result_count", 32'(n_pop), 32'(n_push));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sad_block_accumulator.md
Name: sad_block_accumulator

Overview:
- Motion-estimation SAD engine stage directly upstream of the SAD comparator.
- Consumes a stream of current/reference pixel pairs for one candidate block and accumulates the sum of absolute differences.
- Emits one SAD result per candidate, tagged with the candidate row/column, in the same 32-bit SAD / 8-bit coordinate format the comparator takes as its First/Second inputs.
- Valid/ready on both sides; one candidate in flight at a time.

Parameters:
- PIX_W, 8, pixel bit width (unsigned).
- LANES, 4, pixel pairs accepted per beat.
- BLOCK_W, 8, block width in pixels.
- BLOCK_H, 8, block height in pixels.
- SAD_W, 32, SAD accumulator/output width.
- COORD_W, 8, row/column tag width.

Ports:
- Clk  in  1  rising-edge clock.
- Rst  in  1  asynchronous, active-high reset.
- Start  in  1  pulse: latch CandRow/CandColumn and begin a candidate; honoured only in IDLE.
- CandRow  in  COORD_W  candidate row tag.
- CandColumn  in  COORD_W  candidate column tag.
- PixValid  in  1  pixel beat valid.
- PixReady  out  1  pixel beat accepted when PixValid&&PixReady.
- CurPix  in  LANES*PIX_W  current-block pixels, lane 0 in LSBs.
- RefPix  in  LANES*PIX_W  reference-window pixels, lane-aligned with CurPix.
- SADValid  out  1  result valid.
- SADReady  in  1  downstream accepts result.
- SADOut  out  SAD_W  block SAD.
- SADRowOut  out  COORD_W  tag of SADOut.
- SADColumnOut  out  COORD_W  tag of SADOut.
- Busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock Clk; Rst is asynchronous, active-high.
- Reset values: state IDLE; PixReady=0; SADValid=0; SADOut=0; SADRowOut=0; SADColumnOut=0; Busy=0; accumulator, beat counter and pipeline valid all 0.
- Derived constant: BEATS = BLOCK_W*BLOCK_H/LANES. Elaboration error if the division is not exact or BEATS<1.
- IDLE:
  - PixReady=0.
  - On Start: latch the tags, clear the accumulator and beat counter, go to ACCUM.
- ACCUM:
  - PixReady=1.
  - Per accepted beat: per-lane |Cur-Ref| (PIX_W bits) is summed in an adder tree (PIX_W+clog2(LANES) bits) and registered in stage 1.
  - The following cycle, stage 2 adds the stage-1 sum into the accumulator, zero-extended to SAD_W.
  - Beat counter increments per accepted beat. On the acceptance of beat BEATS-1, PixReady drops the next cycle and the state goes to DRAIN.
  - PixValid low stalls; no bubbles are inserted into the sum.
- DRAIN:
  - Waits one cycle for stage 2 to absorb the last beat.
  - Then loads SADOut and the tags, sets SADValid=1, goes to HOLD.
- HOLD:
  - SADOut/SADRowOut/SADColumnOut/SADValid stay stable until SADValid&&SADReady, then SADValid=0 and the state returns to IDLE.
  - SADOut keeps its last value after the handshake.
- Latency: last beat accepted at cycle N -> SADValid rises at cycle N+2. Minimum candidate period is BEATS+3 cycles (IDLE/Start cycle included).
- Start outside IDLE is ignored (no re-latch, no restart).
- Start and SADReady in the same cycle while in HOLD: the result completes and Start is ignored. A new Start must arrive in IDLE.
- Arithmetic: no overflow is possible for the defaults (max 64*255=16320). SAD_W must be at least PIX_W+clog2(BLOCK_W*BLOCK_H); otherwise elaboration error.
- Rst mid-candidate: immediate return to reset values; partial sum discarded; no SADValid issued.

Optional Feature:
- Macro: SAD_EARLY_TERM_EN.
- Defined:
  - Adds input ThresholdSAD [SAD_W] (sampled at Start) and output EarlyTermOut [1].
  - When the accumulator becomes strictly greater than the latched threshold, further beats are still accepted (keeping the pixel stream aligned) but no longer summed.
  - The result is emitted at the normal time with SADOut = frozen partial sum and EarlyTermOut=1, cleared with SADValid.
  - Equal to threshold does not terminate, consistent with the comparator's <= preference.
- Undefined: ports absent; all beats summed.

Decomposition:
- Package sad_pkg:
  - SAD_W and COORD_W defaults.
  - State enum (IDLE, ACCUM, DRAIN, HOLD).
  - Function computing BEATS.
  - Constant SAD_MAX_INIT=32767 (the comparator's seed value) for shared use.
- Sub-module sad_abs_diff_tree: combinational LANES-wide absolute difference plus adder tree, parameterised on LANES/PIX_W. The instantiating block registers its output.

Test Plan:
- Identical Cur/Ref (all 0x80), CandRow=3, CandColumn=5, 16 beats -> SADOut=0, row 3, column 5, SADValid 2 cycles after the last beat.
- Cur=0xFF, Ref=0x00 every lane -> SADOut=16320. Swap Cur/Ref -> still 16320 (abs symmetric).
- Random pixels with PixValid toggled 50% and SADReady held low 10 cycles -> SADOut matches the model; outputs stable during the hold; one result per candidate.
- Start pulsed during ACCUM with different tags -> ignored; the result carries the original tags.
- Rst asserted after 7 beats -> all outputs 0 the same cycle; a fresh candidate then yields the correct independent SAD.
- SAD_EARLY_TERM_EN defined, ThresholdSAD=100, each beat sum 60 -> accumulation freezes at 120 after beat 2; SADOut=120, EarlyTermOut=1, valid at normal latency. ThresholdSAD=960 with total exactly 960 -> EarlyTermOut=0.
